jt12_ring_wr: RTL and testbench

JT12_RING_WR -- requirements
Module: jt12_ring_wr

---
 rtl/jt12_ring_wr.sv | 115 +++++++++++
 tb/tb_jt12_ring_wr.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/jt12_ring_wr.sv
// rtl/jt12_ring_wr.sv - queued slot writer for an external shift-register ring
//
// Tracks which slot of an external shift-register ring is at ring_out and
// substitutes a queued word for that slot as it passes. Writes are held in a
// two-entry FIFO and committed in acceptance order.
//
// Ports:
//   rst       async active-high reset
//   clk       clock, all state on rising edge
//   clk_en    ring advance enable (one slot per asserted cycle)
//   wr_req    write request, taken when wr_ready=1
//   wr_slot   target slot index
//   wr_data   word to place into the target slot
//   wr_ready  FIFO has room (registered count < 2)
//   wr_err    one-cycle pulse: request rejected, slot out of range
//   wr_done   one-cycle pulse: queued write committed to the ring
//   ring_out  word leaving the ring
//   ring_in   word entering the ring
//   cur_slot  index of the slot currently at ring_out
//   zero      high while cur_slot==0
module jt12_ring_wr #(
    parameter int width = 8,
    parameter int slots = 24
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             clk_en,
    input  logic             wr_req,
    input  logic [4:0]       wr_slot,
    input  logic [width-1:0] wr_data,
    output logic             wr_ready,
    output logic             wr_err,
    output logic             wr_done,
    input  logic [width-1:0] ring_out,
    output logic [width-1:0] ring_in,
    output logic [4:0]       cur_slot,
    output logic             zero
);

    localparam logic [5:0] slot_count = 6'(slots);
    localparam logic [4:0] last_slot  = 5'(slots - 1);

    // FIFO: entry 0 is always the head
    logic [1:0]       count;
    logic [4:0]       slot0;
    logic [4:0]       slot1;
    logic [width-1:0] data0;
    logic [width-1:0] data1;

    logic accept;
    logic legal;
    logic push;
    logic head_hit;

    // Ready depends only on the registered count, so a same-cycle pop never
    // opens room for a push into a full FIFO.
    assign wr_ready = (count < 2'd2);
    assign accept   = wr_req && wr_ready;
    assign legal    = ({1'b0, wr_slot} < slot_count);
    assign push     = accept && legal;

    // Only the registered head can commit, so a write is never substituted
    // on the same edge that accepts it.
    assign head_hit = (count != 2'd0) && clk_en && (slot0 == cur_slot);
    assign ring_in  = head_hit ? data0 : ring_out;
    assign zero     = (cur_slot == 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_slot <= 5'd0;
        end else if (clk_en) begin
            cur_slot <= (cur_slot == last_slot) ? 5'd0 : cur_slot + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 2'd0;
            slot0   <= 5'd0;
            slot1   <= 5'd0;
            data0   <= '0;
            data1   <= '0;
            wr_err  <= 1'b0;
            wr_done <= 1'b0;
        end else begin
            wr_err  <= accept && !legal;
            wr_done <= head_hit;
            case ({push, head_hit})
                2'b01: begin
                    slot0 <= slot1;
                    data0 <= data1;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= wr_slot;
                        data0 <= wr_data;
                    end else begin
                        slot1 <= wr_slot;
                        data1 <= wr_data;
                    end
                    count <= count + 2'd1;
                end
                2'b11: begin
                    // push needs count<2 and pop needs count>0, so count is 1:
                    // the new entry becomes the head and count stays put.
                    slot0 <= wr_slot;
                    data0 <= wr_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jt12_ring_wr.sv
// tb/tb_jt12_ring_wr.sv - self-checking bench for jt12_ring_wr
module tb_jt12_ring_wr;

    localparam int SLOTS = 24;

    logic       rst;
    logic       clk;
    logic       clk_en;
    logic       wr_req;
    logic [4:0] wr_slot;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       wr_err;
    logic       wr_done;
    logic [7:0] ring_out;
    logic [7:0] ring_in;
    logic [4:0] cur_slot;
    logic       zero;

    jt12_ring_wr #(.width(8), .slots(SLOTS)) dut (
        .rst      (rst),
        .clk      (clk),
        .clk_en   (clk_en),
        .wr_req   (wr_req),
        .wr_slot  (wr_slot),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .wr_err   (wr_err),
        .wr_done  (wr_done),
        .ring_out (ring_out),
        .ring_in  (ring_in),
        .cur_slot (cur_slot),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] slot;
        logic [7:0] data;
        int         age;
    } wr_t;

    wr_t        q[$];
    logic [7:0] ring_mem[SLOTS];
    logic [7:0] ref_mem[SLOTS];
    int         m_cur;
    logic       m_err;
    logic       m_done;
    int         checks;
    int         failures;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check after settling, advance model.
    task automatic step(input logic en, input logic req, input logic [4:0] slot, input logic [7:0] data);
        logic       hit;
        logic       acc;
        logic       legal;
        logic [7:0] exp_in;
        clk_en   = en;
        wr_req   = req;
        wr_slot  = slot;
        wr_data  = data;
        ring_out = ring_mem[m_cur];
        #1;
        check_eq("cur_slot", 32'(cur_slot), 32'(m_cur));
        check_eq("zero", 32'(zero), 32'(m_cur == 0));
        check_eq("wr_ready", 32'(wr_ready), 32'(q.size() < 2));
        check_eq("wr_err", 32'(wr_err), 32'(m_err));
        check_eq("wr_done", 32'(wr_done), 32'(m_done));
        hit    = en && (q.size() > 0) && (q[0].slot == 5'(m_cur));
        exp_in = hit ? q[0].data : ring_out;
        check_eq("ring_in", 32'(ring_in), 32'(exp_in));
        acc   = req && (q.size() < 2);
        legal = (int'(slot) < SLOTS);
        if (en) begin
            ring_mem[m_cur] = ring_in;
            for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
        end
        if (hit) begin
            ref_mem[m_cur] = q[0].data;
            check_eq("latency", 32'(q[0].age <= 2 * SLOTS), 32'd1);
            void'(q.pop_front());
        end
        m_done = hit;
        m_err  = acc && !legal;
        if (acc && legal) q.push_back('{slot: slot, data: data, age: 0});
        if (en) m_cur = (m_cur == SLOTS - 1) ? 0 : m_cur + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 8'd0);
    endtask

    task automatic goto_slot(input int target);
        for (int i = 0; i < SLOTS && m_cur != target; i++) step(1'b1, 1'b0, 5'd0, 8'd0);
    endtask

    // Asserted at a negedge, so it lands in the middle of whatever is pending.
    task automatic reset_for(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            clk_en   = 1'b1;
            wr_req   = 1'b1;
            wr_slot  = 5'd0;
            wr_data  = 8'hEE;
            ring_out = ring_mem[0];
            #1;
            check_eq("rst_cur_slot", 32'(cur_slot), 32'd0);
            check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
            check_eq("rst_wr_err", 32'(wr_err), 32'd0);
            check_eq("rst_wr_done", 32'(wr_done), 32'd0);
            check_eq("rst_ring_in", 32'(ring_in), 32'(ring_out));
            @(posedge clk);
            @(negedge clk);
        end
        rst    = 1'b0;
        wr_req = 1'b0;
        q.delete();
        m_cur  = 0;
        m_err  = 1'b0;
        m_done = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clk_en   = 1'b0;
        wr_req   = 1'b0;
        wr_slot  = 5'd0;
        wr_data  = 8'd0;
        m_cur    = 0;
        m_err    = 1'b0;
        m_done   = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            ring_mem[i] = 8'($urandom);
            ref_mem[i]  = ring_mem[i];
        end
        ring_out = ring_mem[0];
        @(negedge clk);
        reset_for(2);

        // full pass then wrap back to slot 0
        idle(SLOTS + 1);

        // write slot 5 from slot 3
        goto_slot(3);
        step(1'b1, 1'b1, 5'd5, 8'hA5);
        idle(4);

        // write slot 7 while slot 7 is passing: commits one full pass later
        goto_slot(7);
        step(1'b1, 1'b1, 5'd7, 8'h11);
        idle(SLOTS + 1);

        // three back-to-back: third is blocked by a full FIFO
        step(1'b1, 1'b1, 5'd2, 8'h21);
        step(1'b1, 1'b1, 5'd2, 8'h22);
        step(1'b1, 1'b1, 5'd9, 8'h99);
        idle(2 * SLOTS + 2);

        // illegal slot
        step(1'b1, 1'b1, 5'd30, 8'h30);
        step(1'b1, 1'b0, 5'd0, 8'd0);
        idle(2);

        // slow clk_en with two writes pending, then reset mid-wait
        goto_slot(10);
        step(1'b1, 1'b1, 5'd4, 8'h44);
        step(1'b0, 1'b1, 5'd6, 8'h66);
        for (int i = 0; i < 9; i++) step(i % 3 == 0, 1'b0, 5'd0, 8'd0);
        reset_for(2);
        idle(2 * SLOTS + 2);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] s;
            if ($urandom_range(0, 399) == 0) begin
                reset_for(1);
            end else begin
                s = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(SLOTS, 31))
                                                : 5'($urandom_range(0, SLOTS - 1));
                step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, s, 8'($urandom));
            end
        end

        // drain and compare the whole ring
        idle(2 * SLOTS + 2);
        for (int i = 0; i < SLOTS; i++) check_eq("ring_contents", 32'(ring_mem[i]), 32'(ref_mem[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
